// File: rtl/aes_key_expand_stream_if.sv
// Round-key word stream between the key-expansion engine (master) and the
// round-key store (slave): one 32-bit word per valid/ready handshake.
interface aes_key_expand_stream_if #(
   parameter int IDX_W = 6
) ();
   logic             w_valid;
   logic             w_ready;
   logic [31:0]      w_data;
   logic [IDX_W-1:0] w_index;
   logic             w_last;

   modport master (
      output w_valid,
      output w_data,
      output w_index,
      output w_last,
      input  w_ready
   );

   modport slave (
      input  w_valid,
      input  w_data,
      input  w_index,
      input  w_last,
      output w_ready
   );
endinterface

// File: rtl/aes_key_expand_stream.sv
// Sequential AES-128/192/256 key schedule streaming w[0..4*(Nr+1)-1] over a
// valid/ready port. Define KEYEXP_ZEROIZE_EN to wipe key material after each run.
module aes_key_expand_stream #(
   parameter int SBOX_LAT = 1,
   parameter int IDX_W    = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [1:0]              key_len,
   input  logic [255:0]            key_in,
   output logic                    busy,
   output logic                    done,
   aes_key_expand_stream_if.master w_if
);

   typedef enum logic [2:0] {IDLE, KEYOUT, CALC, SUBWAIT, EMIT, FIN} state_e;

   localparam logic [1:0] WAIT_LAST = (SBOX_LAT > 1) ? 2'(SBOX_LAT - 1) : 2'd0;

   // Byte x of the forward S-box sits at bits [8*(255-x) +: 8].
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TABLE[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] r);
      return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] key_word(input logic [255:0] key, input logic [2:0] idx);
      return key[{~idx, 5'b00000} +: 32];
   endfunction

   state_e           state_q, state_d;
   logic [255:0]     key_q, key_d;
   logic [2:0]       nk_m1_q, nk_m1_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [IDX_W-1:0] i_q, i_d;
   logic [2:0]       pos_q, pos_d;
   logic [7:0]       rcon_q, rcon_d;
   logic [1:0]       wait_q, wait_d;
   logic [31:0]      w_data_q, w_data_d;
   logic [31:0]      win_q [8];
   logic [31:0]      win_d [8];

   logic        valid;
   logic        handshake;
   logic [31:0] newest;
   logic [31:0] oldest;
   logic        rcon_step;
   logic        need_sub;
   logic [31:0] sbox_in;
   logic [31:0] sub_comb;
   logic [31:0] sub_out;
   logic [31:0] sub_temp;
   logic [2:0]  pos_next;

   // win_q[0] is the newest word; the word Nk positions back is win_q[Nk-1].
   assign newest    = win_q[0];
   assign oldest    = win_q[nk_m1_q];
   assign rcon_step = (pos_q == 3'd0);
   assign need_sub  = rcon_step || (nk_m1_q == 3'd7 && pos_q == 3'd4);
   assign sbox_in   = rcon_step ? {newest[23:0], newest[31:24]} : newest;
   assign sub_comb  = sub_word(sbox_in);
   assign sub_temp  = sub_out ^ (rcon_step ? {rcon_q, 24'h000000} : 32'h0);
   assign pos_next  = (pos_q == nk_m1_q) ? 3'd0 : pos_q + 3'd1;

   assign valid     = (state_q == KEYOUT) || (state_q == EMIT);
   assign handshake = valid && w_if.w_ready;

   assign w_if.w_valid = valid;
   assign w_if.w_index = i_q;
   assign w_if.w_last  = valid && (i_q == last_q);
   assign busy         = state_q inside {KEYOUT, CALC, SUBWAIT, EMIT};
   assign done         = (state_q == FIN);

`ifdef KEYEXP_ZEROIZE_EN
   assign w_if.w_data = valid ? w_data_q : 32'h0;
`else
   assign w_if.w_data = w_data_q;
`endif

   // SubWord result: combinational, or delayed by SBOX_LAT registers that only
   // advance while a SubWord word is being computed.
   generate
      if (SBOX_LAT == 0) begin : g_sbox_comb
         assign sub_out = sub_comb;
      end else begin : g_sbox_pipe
         logic [31:0] pipe_q [SBOX_LAT];
         logic [31:0] pipe_d [SBOX_LAT];

         always_comb begin
            pipe_d = pipe_q;
            if (state_q == CALC || state_q == SUBWAIT) begin
               pipe_d[0] = sub_comb;
               for (int k = 1; k < SBOX_LAT; k++) pipe_d[k] = pipe_q[k-1];
            end
`ifdef KEYEXP_ZEROIZE_EN
            if (state_q == FIN) begin
               for (int k = 0; k < SBOX_LAT; k++) pipe_d[k] = 32'h0;
            end
`endif
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               for (int k = 0; k < SBOX_LAT; k++) pipe_q[k] <= 32'h0;
            end else begin
               pipe_q <= pipe_d;
            end
         end

         assign sub_out = pipe_q[SBOX_LAT-1];
      end
   endgenerate

   // NOTE: every _d gets its _q as default first, so no path through this block
   // leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_d  = state_q;
      key_d    = key_q;
      nk_m1_d  = nk_m1_q;
      last_d   = last_q;
      i_d      = i_q;
      pos_d    = pos_q;
      rcon_d   = rcon_q;
      wait_d   = wait_q;
      w_data_d = w_data_q;
      win_d    = win_q;

      if (handshake) begin
         win_d[0] = w_data_q;
         for (int k = 1; k < 8; k++) win_d[k] = win_q[k-1];
         i_d   = i_q + IDX_W'(1);
         pos_d = pos_next;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               key_d = key_in;
               case (key_len)
                  2'b01: begin
                     nk_m1_d = 3'd5;
                     last_d  = IDX_W'(51);
                  end
                  2'b10: begin
                     nk_m1_d = 3'd7;
                     last_d  = IDX_W'(59);
                  end
                  default: begin
                     nk_m1_d = 3'd3;
                     last_d  = IDX_W'(43);
                  end
               endcase
               i_d      = '0;
               pos_d    = 3'd0;
               rcon_d   = 8'h01;
               w_data_d = key_in[255:224];
               state_d  = KEYOUT;
            end
         end

         KEYOUT: begin
            if (handshake) begin
               if (pos_q == nk_m1_q) begin
                  state_d = CALC;
               end else begin
                  w_data_d = key_word(key_q, pos_q + 3'd1);
               end
            end
         end

         CALC: begin
            if (!need_sub) begin
               w_data_d = oldest ^ newest;
               state_d  = EMIT;
            end else if (SBOX_LAT == 0) begin
               w_data_d = oldest ^ sub_temp;
               state_d  = EMIT;
            end else begin
               wait_d  = 2'd0;
               state_d = SUBWAIT;
            end
         end

         SUBWAIT: begin
            if (wait_q == WAIT_LAST) begin
               w_data_d = oldest ^ sub_temp;
               state_d  = EMIT;
            end else begin
               wait_d = wait_q + 2'd1;
            end
         end

         EMIT: begin
            if (handshake) begin
               if (rcon_step) rcon_d = xtime(rcon_q);
               state_d = (i_q == last_q) ? FIN : CALC;
            end
         end

         FIN: begin
            state_d = IDLE;
`ifdef KEYEXP_ZEROIZE_EN
            key_d    = '0;
            w_data_d = 32'h0;
            for (int k = 0; k < 8; k++) win_d[k] = 32'h0;
`endif
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // the pre-edge value of every other flop. The window is reset like any other
   // register because an aborted run must not leave key material behind.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         key_q    <= '0;
         nk_m1_q  <= 3'd0;
         last_q   <= '0;
         i_q      <= '0;
         pos_q    <= 3'd0;
         rcon_q   <= 8'h00;
         wait_q   <= 2'd0;
         w_data_q <= 32'h0;
         for (int k = 0; k < 8; k++) win_q[k] <= 32'h0;
      end else begin
         state_q  <= state_d;
         key_q    <= key_d;
         nk_m1_q  <= nk_m1_d;
         last_q   <= last_d;
         i_q      <= i_d;
         pos_q    <= pos_d;
         rcon_q   <= rcon_d;
         wait_q   <= wait_d;
         w_data_q <= w_data_d;
         win_q    <= win_d;
      end
   end

endmodule

// File: doc/aes_key_expand_stream.md
Name: aes_key_expand_stream

Overview:
- Sequential AES key-schedule engine supporting AES-128, AES-192 and AES-256, selected per run by `key_len`.
- Streams every round-key word w[0..4*(Nr+1)-1] over a valid/ready interface to the round-key store.
- Generalises the single-step G function: adds mode selection, the AES-256 SubWord-only step, an internal Rcon sequencer, a sliding Nk-word window and a pipelined S-box with configurable latency.

Parameters:
- SBOX_LAT, 1: register stages inside SubWord, legal range 0..2; 0 means a combinational S-box.
- IDX_W, 6: width of `w_index`; must be at least 6 (covers 0..59).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  begin expansion; sampled only in IDLE.
- key_len  in  2  mode: 00 = AES-128 (Nk=4, 44 words), 01 = AES-192 (Nk=6, 52 words), 10 = AES-256 (Nk=8, 60 words), 11 = reserved, treated as 00.
- key_in  in  256  cipher key, left-aligned; w0 = key_in[255:224]; unused low bits ignored.
- busy  out  1  high from the cycle after start is accepted until done.
- w_valid  out  1  `w_data` holds a valid word.
- w_ready  in  1  consumer accepts the word.
- w_data  out  32  round-key word.
- w_index  out  IDX_W  index i of `w_data`.
- w_last  out  1  high with the final word.
- done  out  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE; `busy`, `w_valid`, `w_last`, `done` = 0; `w_data` = 0; `w_index` = 0; window, Rcon and counters cleared. Reset mid-run aborts the run; no `done` is produced.
- FSM states: IDLE, KEYOUT, CALC, SUBWAIT, EMIT, FIN.
- IDLE: on start=1, latch `key_in`, `key_len` and Nk; set i=0 and Rcon=0x01; go to KEYOUT. `start` is ignored in every other state.
- KEYOUT: present key word i (i < Nk) with `w_valid`=1.
  - On handshake: push the word into the window, i++.
  - When i reaches Nk, go to CALC.
- CALC: temp = window newest word (w[i-1]).
  - If i mod Nk == 0: temp' = SubWord(RotWord(temp)) XOR {Rcon,24'h0}; go to SUBWAIT.
  - Else if Nk==8 and i mod 8 == 4: temp' = SubWord(temp); go to SUBWAIT.
  - Otherwise temp' = temp; go to EMIT next cycle.
- SUBWAIT: wait SBOX_LAT cycles, then go to EMIT. With SBOX_LAT=0, CALC goes straight to EMIT.
- EMIT: w_data = window oldest word (w[i-Nk]) XOR temp'; `w_valid`=1.
  - `w_data`, `w_index` and `w_last` stay stable while w_valid=1 and w_ready=0.
  - On handshake: shift the window, i++; if the word used Rcon, Rcon = xtime(Rcon) (0x80 -> 0x1B).
  - If the word was last, go to FIN; else go to CALC.
- FIN: done=1 and busy=0 for one cycle, then IDLE.
- Throughput with w_ready tied high:
  - Key words: 1 per cycle.
  - Plain words: 2 cycles each (CALC + EMIT).
  - SubWord words: 2 + SBOX_LAT cycles each.
- First `w_valid` occurs the cycle after `start` is accepted.
- w_index == i; w_last=1 exactly when i == 4*(Nr+1)-1.
- Window: 8x32 shift register; only the newest Nk entries are used.
- start coincident with FIN: ignored, because the FSM is not yet in IDLE.

Optional Feature:
- Macro: KEYEXP_ZEROIZE_EN.
- Defined:
  - In FIN, the window, latched key, temp and S-box pipeline registers are cleared to 0.
  - `w_data` is forced to 0 whenever w_valid=0.
- Undefined:
  - Registers retain their contents after the run.
  - `w_data` holds the last emitted word until the next run.

Test Plan:
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, w_ready=1 -> w4=a0fafe17, w43=b6630ca6 with w_last=1; 44 handshakes; done one cycle later.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> w6=fe0c91f7, w51=01002202, w_last at index 51.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> w8=9ba35411, w12=a8b09c1a (SubWord-only step), w59=706c631e.
- Random w_ready backpressure on the AES-128 run -> identical 44-word sequence; `w_data` and `w_index` stable while stalled; no word dropped or duplicated.
- rst=0 at w20 of an AES-256 run, then a new AES-128 start -> outputs 0 immediately; new run is correct from w0; no `done` for the aborted run.
- key_len=11 -> behaves as AES-128 (44 words). start pulsed while busy -> ignored, sequence unaffected.
- Each vector repeated with SBOX_LAT=0 and SBOX_LAT=2 -> same words; cycle count changes only by the SubWord stalls.
